tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 127 ++++++++++++
 tb/tb_tmds_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder: transition-minimised, DC-balanced video
// symbols during VDE=1, control tokens during blanking. Define TMDS_PIPE_EN to register stage 1 (latency 2).
module tmds_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] VD,
    input  logic [1:0] CD,
    input  logic       VDE,
    output logic [9:0] TMDS
);

    logic [3:0]        n1d;
    logic              use_xnor;
    logic [8:0]        q_m_next;
    logic [3:0]        n1q_next;

    logic [8:0]        s2_q_m;
    logic [3:0]        s2_n1q;
    logic [3:0]        s2_n0q;
    logic              s2_vde;
    logic [1:0]        s2_cd;

    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic signed [4:0] diff;
    logic [9:0]        tmds_reg;
    logic [9:0]        tmds_next;

    // Stage 1: pick the chain that yields fewer transitions.
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, VD[i]};
        end
    end

    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !VD[0]);

    always_comb begin
        q_m_next    = '0;
        q_m_next[0] = VD[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ VD[i]) : (q_m_next[i-1] ^ VD[i]);
        end
        q_m_next[8] = ~use_xnor;
    end

    always_comb begin
        n1q_next = '0;
        for (int i = 0; i < 8; i++) begin
            n1q_next = n1q_next + {3'b000, q_m_next[i]};
        end
    end

`ifdef TMDS_PIPE_EN
    logic [8:0] q_m_reg;
    logic [3:0] n1q_reg;
    logic       vde_reg;
    logic [1:0] cd_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_m_reg <= '0;
            n1q_reg <= '0;
            vde_reg <= 1'b0;
            cd_reg  <= 2'b00;
        end else begin
            q_m_reg <= q_m_next;
            n1q_reg <= n1q_next;
            vde_reg <= VDE;
            cd_reg  <= CD;
        end
    end

    assign s2_q_m = q_m_reg;
    assign s2_n1q = n1q_reg;
    assign s2_vde = vde_reg;
    assign s2_cd  = cd_reg;
`else
    assign s2_q_m = q_m_next;
    assign s2_n1q = n1q_next;
    assign s2_vde = VDE;
    assign s2_cd  = CD;
`endif

    assign s2_n0q = 4'd8 - s2_n1q;
    assign diff   = signed'({1'b0, s2_n1q}) - signed'({1'b0, s2_n0q});

    // Stage 2: choose polarity so the running disparity is pulled toward zero.
    always_comb begin
        tmds_next = 10'h354;
        cnt_next  = 5'sd0;
        if (s2_vde) begin
            if ((cnt_reg == 5'sd0) || (s2_n1q == s2_n0q)) begin
                tmds_next = {~s2_q_m[8], s2_q_m[8], s2_q_m[8] ? s2_q_m[7:0] : ~s2_q_m[7:0]};
                cnt_next  = cnt_reg + (s2_q_m[8] ? diff : -diff);
            end else if (((cnt_reg > 5'sd0) && (s2_n1q > s2_n0q)) ||
                         ((cnt_reg < 5'sd0) && (s2_n0q > s2_n1q))) begin
                tmds_next = {1'b1, s2_q_m[8], ~s2_q_m[7:0]};
                cnt_next  = cnt_reg + (s2_q_m[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                tmds_next = {1'b0, s2_q_m[8], s2_q_m[7:0]};
                cnt_next  = cnt_reg + diff - (s2_q_m[8] ? 5'sd0 : 5'sd2);
            end
        end else begin
            case (s2_cd)
                2'b00:   tmds_next = 10'h354;
                2'b01:   tmds_next = 10'h0AB;
                2'b10:   tmds_next = 10'h154;
                default: tmds_next = 10'h2AB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmds_reg <= 10'h354;
            cnt_reg  <= 5'sd0;
        end else begin
            tmds_reg <= tmds_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign TMDS = tmds_reg;

endmodule

// File: tb/tb_tmds_encoder.sv
// Randomised bench for tmds_encoder: symbol-level reference model, decode-back
// and running-disparity checks, plus directed token/reset/VDE-edge cases.
module tb_tmds_encoder;

`ifdef TMDS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] vd      = '0;
    logic [1:0] cd      = '0;
    logic       vde     = 1'b0;
    logic [9:0] tmds;

    typedef struct {
        logic [9:0] sym;
        bit         active;
        logic [7:0] vd;
        int         lit;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    int   cum     = 0;

    tmds_encoder dut (
        .clk  (clk),
        .reset(reset),
        .VD   (vd),
        .CD   (cd),
        .VDE  (vde),
        .TMDS (tmds)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Symbol the standard prescribes for these inputs, given the model's disparity.
    function automatic logic [9:0] model(input logic v, input logic [1:0] c, input logic [7:0] d);
        int         ones;
        int         disp;
        bit         sel_xnor;
        logic [7:0] qm;
        logic       q8;
        logic [9:0] s;
        if (!v) begin
            m_cnt = 0;
            case (c)
                2'd0:    s = 10'h354;
                2'd1:    s = 10'h0AB;
                2'd2:    s = 10'h154;
                default: s = 10'h2AB;
            endcase
            return s;
        end
        ones     = $countones(d);
        sel_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) qm[i] = sel_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8   = !sel_xnor;
        disp = 2 * $countones(qm) - 8;
        if (m_cnt == 0 || disp == 0) begin
            s     = q8 ? {2'b01, qm} : {2'b10, ~qm};
            m_cnt = m_cnt + (q8 ? disp : -disp);
        end else if ((m_cnt > 0 && disp > 0) || (m_cnt < 0 && disp < 0)) begin
            s     = {1'b1, q8, ~qm};
            m_cnt = m_cnt + (q8 ? 2 : 0) - disp;
        end else begin
            s     = {1'b0, q8, qm};
            m_cnt = m_cnt + disp - (q8 ? 0 : 2);
        end
        return s;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] dd;
        logic [7:0] o;
        dd   = s[9] ? ~s[7:0] : s[7:0];
        o[0] = dd[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
        return o;
    endfunction

    task automatic step(input logic v, input logic [1:0] c, input logic [7:0] d,
                        input int lit = -1, input string tag = "lit");
        exp_t e;
        vde      = v;
        cd       = c;
        vd       = d;
        e.sym    = model(v, c, d);
        e.active = v;
        e.vd     = d;
        e.lit    = lit;
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("[TB] vde=%0b cd=%0d vd=%02h -> tmds=%03h", v, c, d, tmds);
        check_eq("sym", 32'(tmds), 32'(e.sym));
        if (e.lit >= 0) check_eq(e.tag, 32'(tmds), e.lit);
        if (e.active) begin
            check_eq("decode", 32'(decode(tmds)), 32'(e.vd));
            cum = cum + 2 * $countones(tmds) - 10;
            check_eq("disp_bound", 32'(cum > 10 || cum < -10), 32'd0);
        end else begin
            cum = 0;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        #1;
        check_eq("rst_async", 32'(tmds), 32'h354);
        @(posedge clk);
        #1;
        check_eq("rst_hold", 32'(tmds), 32'h354);
        reset = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        cum   = 0;
        for (int i = 0; i < LAT - 1; i++) begin
            e.sym    = 10'h354;
            e.active = 1'b0;
            e.vd     = '0;
            e.lit    = -1;
            e.tag    = "pipe";
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int active_seen;
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_noclk", 32'(tmds), 32'h354);
        #20;
        check_eq("rst_noclk_hold", 32'(tmds), 32'h354);
        clk_run = 1'b1;
        do_reset();

        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'($urandom), 10'h354, "blank354");
        step(1'b0, 2'd1, 8'($urandom), 10'h0AB, "tok01");
        step(1'b0, 2'd2, 8'($urandom), 10'h154, "tok10");
        step(1'b0, 2'd3, 8'($urandom), 10'h2AB, "tok11");

        step(1'b1, 2'd3, 8'h00, 10'h100, "zero_a");
        step(1'b1, 2'd2, 8'h00, 10'h3FF, "zero_b");
        step(1'b1, 2'd1, 8'h00, 10'h100, "zero_c");
        step(1'b0, 2'd0, 8'h00, 10'h354, "blank_gap");
        step(1'b1, 2'd0, 8'hFF, 10'h200, "xnor_ff");

        active_seen = 0;
        while (active_seen < 10000) begin
            logic v;
            v = ($urandom_range(15) != 0);
            if (v) active_seen++;
            step(v, 2'($urandom), 8'($urandom));
        end

        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom), 8'($urandom));
            step(1'b0, 2'd1, 8'($urandom), 10'h0AB, "gap_tok");
            step(1'b1, 2'd2, 8'h00, 10'h100, "gap_first");
        end

        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'($urandom));
        do_reset();
        step(1'b1, 2'd0, 8'h00, 10'h100, "post_rst");
        for (int i = 0; i < 8; i++) step(1'b1, 2'($urandom), 8'($urandom));
        step(1'b0, 2'd2, 8'h00, 10'h154, "end_tok");
        for (int i = 0; i < LAT - 1; i++) step(1'b0, 2'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
